router_pkt_tx: RTL and testbench
================================

ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

Interface
REQ-001 clock  input  1  single system clock; all state changes on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 start  input  1  request to send one packet; sampled only when ready=1.
REQ-004 dest_addr  input  2  destination port 0..2; value 3 is illegal.
REQ-005 pay_len  input  6  payload byte count 1..63; 0 is illegal.
REQ-006 pay_avail  input  1  payload source holds at least pay_len bytes; start is ignored while low.
REQ-007 pay_data  input  8  show-ahead payload byte, valid in the same cycle as pay_rd.
REQ-008 pay_rd  output  1  combinational pop strobe to the payload source, one byte per asserted cycle.
REQ-009 busy  input  1  router back-pressure; the output byte is not accepted at an edge where busy=1.
REQ-010 data_in  output  8  registered byte to the router input.
REQ-011 pkt_valid  output  1  registered; 1 for header and payload, 0 for parity.
REQ-012 ready  output  1  1 only in IDLE.
REQ-013 done  output  1  one-cycle pulse after the parity byte is accepted.
REQ-014 start_err  output  1  one-cycle pulse when start is rejected.

Function
REQ-015 The FSM states SHALL be IDLE, HEADER, PAYLOAD and PARITY.
REQ-016 In IDLE, start=1 with pay_avail=1, dest_addr!=3 and pay_len!=0 SHALL latch the length and load data_in={pay_len,dest_addr}, set pkt_valid=1 and go to HEADER at that edge.
REQ-017 In IDLE, start=1 with dest_addr=3 or pay_len=0 SHALL pulse start_err for the next cycle and remain in IDLE.
REQ-018 In IDLE, start=1 with pay_avail=0 SHALL be ignored silently.
REQ-019 A byte SHALL count as accepted at a rising edge where the FSM is not IDLE and busy=0.
REQ-020 While busy=1, data_in, pkt_valid, the state and the counters SHALL hold, and pay_rd SHALL be 0.
REQ-021 pay_rd SHALL equal 1 in a cycle where busy=0 and the state is HEADER, or the state is PAYLOAD with fewer than pay_len bytes sent.
REQ-022 On each accepted header or payload byte with bytes remaining, the next edge SHALL load pay_data into data_in with pkt_valid=1 and increment the sent count.
REQ-023 Parity SHALL be the running XOR of the header and every payload byte loaded, and SHALL be cleared when the header is loaded.
REQ-024 When the last payload byte is accepted, the next edge SHALL load data_in=parity, set pkt_valid=0 and go to PARITY.
REQ-025 When the parity byte is accepted, the FSM SHALL go to IDLE, drive data_in=0 and pkt_valid=0, and pulse done for one cycle.
REQ-026 Unblocked packet timing: header 1 cycle, payload pay_len cycles, parity 1 cycle; ready SHALL return on the cycle after parity acceptance.
REQ-027 start SHALL be ignored outside IDLE; a start on the same cycle as the done pulse SHALL be accepted, giving back-to-back packets.
REQ-028 busy SHALL be ignored in IDLE.
REQ-029 The packet length and address SHALL be latched at start; later changes to pay_len or dest_addr SHALL not affect the packet in flight.

Reset
REQ-030 reset=1 at a rising edge SHALL force IDLE, data_in=0, pkt_valid=0, done=0, start_err=0, and clear the parity and counter.
REQ-031 After reset, ready SHALL be 1 and pay_rd SHALL be 0.
REQ-032 A reset during any state SHALL abort the packet with no done pulse, and pay_rd SHALL be 0 in the reset cycle.
REQ-033 reset SHALL take priority over start and busy.

Verification
REQ-034 addr=1, len=16, busy=0, payload 0x01..0x10 -> data_in sequence 0x41, 0x01..0x10, then parity 0x41^0x01^...^0x10=0x51 with pkt_valid=0; exactly 16 pay_rd pulses; done one cycle later; 18 data cycles total.
REQ-035 Same packet with busy=1 for 3 cycles while payload byte 5 is driven -> byte 5 holds for 4 cycles with pay_rd=0 during the stall; sequence and parity unchanged; total 21 data cycles.
REQ-036 start with addr=3, then start with len=0 -> start_err pulses each time; no pay_rd; ready stays 1; pkt_valid stays 0.
REQ-037 len=1, addr=2, payload 0xA5 -> sequence 0x06, 0xA5, parity 0xA3; two back-to-back such packets with start on the done cycle -> no idle gap beyond one cycle.
REQ-038 reset asserted mid-PAYLOAD (byte 7 of 16) -> next cycle data_in=0, pkt_valid=0, ready=1, no done; a following packet is sent with correct parity.
REQ-039 start pulsed again mid-packet, and pay_len/dest_addr changed mid-packet -> ignored; the in-flight packet completes unchanged.

Source files
------------

// File: rtl/router_pkt_tx.sv
// Packet transmitter feeding a router input: sends a header byte {len,addr}, the
// payload pulled from a show-ahead source, then an XOR parity byte.
module router_pkt_tx (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic [1:0] dest_addr_i,
    input  logic [5:0] pay_len_i,
    input  logic       pay_avail_i,
    input  logic [7:0] pay_data_i,
    output logic       pay_rd_o,
    input  logic       busy_i,
    output logic [7:0] data_in_o,
    output logic       pkt_valid_o,
    output logic       ready_o,
    output logic       done_o,
    output logic       start_err_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2,
        PARITY  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] len_q, len_d;
    logic [5:0] sent_q, sent_d;
    logic [7:0] data_q, data_d;
    logic [7:0] parity_q, parity_d;
    logic       valid_q, valid_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic       start_req;
    logic       start_legal;
    logic       accept;
    logic       more_bytes;
    logic       fetch;

    // A start is only considered when the payload source can cover the packet.
    assign start_req   = start_i && pay_avail_i;
    assign start_legal = (dest_addr_i != 2'd3) && (pay_len_i != 6'd0);
    assign accept      = (state_q != IDLE) && !busy_i;
    assign more_bytes  = (sent_q < len_q);
    assign fetch       = accept &&
                         ((state_q == HEADER) || ((state_q == PAYLOAD) && more_bytes));

    // State register
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_req && start_legal) begin
                    state_d = HEADER;
                end
            end
            HEADER: begin
                if (accept) begin
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (accept && !more_bytes) begin
                    state_d = PARITY;
                end
            end
            PARITY: begin
                if (accept) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic; the pop strobe is squashed during reset so no byte is lost.
    always_comb begin
        pay_rd_o = fetch && !reset_i;
        ready_o  = (state_q == IDLE);
    end

    // Datapath next-state
    always_comb begin
        len_d    = len_q;
        sent_d   = sent_q;
        data_d   = data_q;
        parity_d = parity_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_req && start_legal) begin
                    len_d    = pay_len_i;
                    sent_d   = 6'd0;
                    data_d   = {pay_len_i, dest_addr_i};
                    parity_d = {pay_len_i, dest_addr_i};
                    valid_d  = 1'b1;
                end else if (start_req) begin
                    err_d = 1'b1;
                end
            end
            HEADER, PAYLOAD: begin
                if (fetch) begin
                    data_d   = pay_data_i;
                    parity_d = parity_q ^ pay_data_i;
                    sent_d   = sent_q + 6'd1;
                    valid_d  = 1'b1;
                end else if (accept) begin
                    data_d  = parity_q;
                    valid_d = 1'b0;
                end
            end
            PARITY: begin
                if (accept) begin
                    data_d  = 8'h00;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                data_d  = 8'h00;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            len_q    <= 6'd0;
            sent_q   <= 6'd0;
            data_q   <= 8'h00;
            parity_q <= 8'h00;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            len_q    <= len_d;
            sent_q   <= sent_d;
            data_q   <= data_d;
            parity_q <= parity_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign data_in_o   = data_q;
    assign pkt_valid_o = valid_q;
    assign done_o      = done_q;
    assign start_err_o = err_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Randomized bench for router_pkt_tx: a packet-level model pushes expected bytes,
// a monitor pops and compares each byte the router accepts.
module tb_router_pkt_tx;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] dest_addr;
    logic [5:0] pay_len;
    logic       pay_avail;
    logic [7:0] pay_data;
    logic       pay_rd;
    logic       busy;
    logic [7:0] data_in;
    logic       pkt_valid;
    logic       ready;
    logic       done;
    logic       start_err;

    router_pkt_tx dut (
        .clock_i     (clk),
        .reset_i     (reset),
        .start_i     (start),
        .dest_addr_i (dest_addr),
        .pay_len_i   (pay_len),
        .pay_avail_i (pay_avail),
        .pay_data_i  (pay_data),
        .pay_rd_o    (pay_rd),
        .busy_i      (busy),
        .data_in_o   (data_in),
        .pkt_valid_o (pkt_valid),
        .ready_o     (ready),
        .done_o      (done),
        .start_err_o (start_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       valid;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] fifo[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         m_left  = 0;
    bit         exp_err_nxt = 1'b0;
    bit         mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic fill_seq(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) fifo.push_back(first + 8'(i));
    endtask

    // One clock cycle: drive inputs, check combinational outputs, advance the model.
    task automatic step(input bit st, input bit [1:0] ad, input bit [5:0] ln,
                        input bit bz, input bit rs, input bit av_off);
        logic [7:0] par;
        logic [7:0] b;
        @(negedge clk);
        start     = st;
        dest_addr = ad;
        pay_len   = ln;
        busy      = bz;
        reset     = rs;
        pay_avail = !av_off && (fifo.size() >= int'(ln));
        pay_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
        #1;
        chk("ready", {31'd0, ready}, {31'd0, (m_left == 0)});
        chk("pay_rd", {31'd0, pay_rd}, {31'd0, (!rs && !bz && m_left > 2)});
        exp_err_nxt = 1'b0;
        if (rs) begin
            m_left = 0;
            exp_q.delete();
        end else if (m_left == 0) begin
            if (st && pay_avail) begin
                if (ad == 2'd3 || ln == 6'd0) begin
                    exp_err_nxt = 1'b1;
                end else begin
                    par = {ln, ad};
                    exp_q.push_back('{data: par, valid: 1'b1});
                    for (int i = 0; i < int'(ln); i++) begin
                        b = fifo[i];
                        par = par ^ b;
                        exp_q.push_back('{data: b, valid: 1'b1});
                    end
                    exp_q.push_back('{data: par, valid: 1'b0});
                    m_left = int'(ln) + 2;
                end
            end
        end else if (!bz) begin
            m_left--;
        end
        if (pay_rd && fifo.size() > 0) void'(fifo.pop_front());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 6'd1, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compares every byte the router accepts against the scoreboard.
    initial begin
        exp_t e;
        bit   done_pend;
        bit   err_pend;
        done_pend = 1'b0;
        err_pend  = 1'b0;
        wait (mon_en);
        forever begin
            @(negedge clk);
            #2;
            chk("done", {31'd0, done}, {31'd0, done_pend});
            chk("start_err", {31'd0, start_err}, {31'd0, err_pend});
            err_pend  = exp_err_nxt;
            done_pend = 1'b0;
            if (ready) begin
                chk("idle_data", {24'd0, data_in}, 32'd0);
                chk("idle_valid", {31'd0, pkt_valid}, 32'd0);
            end else if (!reset && !busy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", {23'd0, data_in, pkt_valid}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("data_in", {24'd0, data_in}, {24'd0, e.data});
                    chk("pkt_valid", {31'd0, pkt_valid}, {31'd0, e.valid});
                    if (!e.valid) done_pend = 1'b1;
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        dest_addr = 2'd0;
        pay_len   = 6'd1;
        pay_avail = 1'b0;
        pay_data  = 8'h00;
        busy      = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_data", {24'd0, data_in}, 32'd0);
        chk("rst_valid", {31'd0, pkt_valid}, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, start_err}, 32'd0);
        chk("rst_pay_rd", {31'd0, pay_rd}, 32'd0);
        mon_en = 1'b1;
        idle(2);

        // addr 1, 16-byte ramp payload, no back-pressure
        fill_seq(8'h01, 16);
        step(1'b1, 2'd1, 6'd16, 1'b0, 1'b0, 1'b0);
        idle(20);

        // same packet with a 3-cycle stall while byte 5 is presented
        fill_seq(8'h01, 16);
        step(1'b1, 2'd1, 6'd16, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 24; i++)
            step(1'b0, 2'd0, 6'd1, (i >= 6 && i <= 8), 1'b0, 1'b0);

        // illegal address, then illegal length, then start without payload
        step(1'b1, 2'd3, 6'd5, 1'b0, 1'b0, 1'b0);
        idle(2);
        step(1'b1, 2'd1, 6'd0, 1'b0, 1'b0, 1'b0);
        idle(2);
        step(1'b1, 2'd1, 6'd40, 1'b0, 1'b0, 1'b0);
        idle(2);

        // two single-byte packets with start held, so the second starts on done
        fifo.push_back(8'hA5);
        fifo.push_back(8'hA5);
        for (int i = 0; i < 10; i++) step(1'b1, 2'd2, 6'd1, 1'b0, 1'b0, 1'b0);
        idle(3);

        // reset while byte 7 of 16 is presented, then a clean packet
        fifo.delete();
        fill_seq(8'h30, 16);
        step(1'b1, 2'd0, 6'd16, 1'b0, 1'b0, 1'b0);
        idle(8);
        step(1'b0, 2'd0, 6'd1, 1'b0, 1'b1, 1'b0);
        idle(3);
        fifo.delete();
        fill_seq(8'h50, 5);
        step(1'b1, 2'd2, 6'd5, 1'b0, 1'b0, 1'b0);
        idle(10);

        // start re-pulsed and len/addr wiggled mid-packet
        fill_seq(8'h90, 40);
        step(1'b1, 2'd1, 6'd6, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++)
            step(1'b1, 2'($urandom_range(0, 2)), 6'($urandom_range(1, 20)), 1'b0, 1'b0, 1'b0);
        idle(4);

        for (int i = 0; i < 500; i++) begin
            bit [5:0] ln;
            int       r;
            if (fifo.size() < 64)
                for (int k = 0; k < 24; k++) fifo.push_back(8'($urandom));
            r  = int'($urandom_range(0, 99));
            ln = (r < 5) ? 6'd0 : (r >= 95) ? 6'($urandom_range(40, 63)) : 6'($urandom_range(1, 12));
            step($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)), ln,
                 $urandom_range(0, 9) < 3, $urandom_range(0, 99) < 2, $urandom_range(0, 9) == 0);
        end

        idle(80);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
